tdm_demux_1to2: RTL and testbench
=================================

// Module: tdm_demux_1to2
// PURPOSE
//  Receive end of the 2:1 time-division link: one serial line carries two
//  channels interleaved bit-by-bit (ch0, ch1, ch0, ...), as driven by a 2:1 mux.
//  Block hunts for frame sync, steers each valid bit to its channel, deserialises
//  both channels, and presents one parallel word per channel per frame.
// PARAMETERS
//  WORD_W     8   bits per channel per frame (>=2)
//  MSB_FIRST  1   1: first bit of a channel in a frame is its MSB; 0: LSB
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  din          in   1        serial TDM data
//  din_valid    in   1        din sampled this cycle when high
//  sync         in   1        qualified by din_valid; marks ch0 bit of frame start
//  sel          out  1        channel the next valid bit is steered to (0/1)
//  out0         out  WORD_W   last complete ch0 word
//  out1         out  WORD_W   last complete ch1 word
//  frame_valid  out  1        1-cycle pulse: out0/out1 updated
//  locked       out  1        high while in RUN
//  sync_err     out  1        1-cycle pulse: sync seen off frame boundary
// BEHAVIOUR
//  Reset (async, any time): state=HUNT, sel=0, bit count=0, shift regs=0,
//   out0=out1=0, frame_valid=0, locked=0, sync_err=0. Partial frame is lost.
//  din_valid=0: no state, count, sel or shift change; pulses deassert.
//  HUNT: din ignored until din_valid&sync; that bit = ch0 first bit;
//   next state RUN, sel->1, count=0.
//  RUN: each din_valid bit shifts into channel sel's register; sel toggles.
//   Count increments after each ch1 bit; after ch1 bit number WORD_W-1:
//   out0/out1 loaded from the full regs, frame_valid=1 next cycle, count->0,
//   sel->0 (frame-to-frame back-to-back with no gap cycle).
//  Sync in RUN at sel=0,count=0: normal frame start, no error.
//  Sync in RUN elsewhere: sync_err=1 next cycle, partial frame discarded
//   (out0/out1 unchanged, no frame_valid), this bit taken as ch0 first bit.
//  Sync coinciding with the completing ch1 bit: frame completes (frame_valid)
//   AND sync_err pulses; that bit is still consumed as ch1 last bit.
//  Latency: frame_valid rises the cycle after the last ch1 bit is sampled;
//   out0/out1 hold until the next completed frame.
//  Width: count is $clog2(WORD_W) bits; wraps only via explicit reload to 0.
//  locked = (state==RUN); only reset returns to HUNT.
// STRUCTURE
//  tdm_defs.vh (shared with the TDM transmit side): state encodings
//   ST_HUNT=1'b0, ST_RUN=1'b1; channel ids CH0=0, CH1=1; default WORD_W.
//  Sub-module tdm_shift_reg (WORD_W, MSB_FIRST; clk, rst_n, clr, en, d, q),
//   instantiated twice (ch0, ch1); top holds FSM, sel, count, output regs.
// TESTING  (WORD_W=4, MSB_FIRST=1 unless stated)
//  1 Reset, then din=1 x10 with sync=0 -> locked=0, out0=out1=0, no pulses.
//  2 Stream 1,0,0,1,1,0,0,1 (sync on 1st) -> one frame_valid, out0=4'hA,
//    out1=4'h5, sel back to 0, locked=1.
//  3 Two frames back-to-back (A/5 then 3/C), din_valid gaps mid-frame
//    -> frame_valid twice, final out0=4'h3, out1=4'hC, gaps change nothing.
//  4 After 3 bits of a frame assert sync -> sync_err pulse, prior out0/out1
//    held, following 8 bits give a correct frame.
//  5 rst_n low for 1 ns mid-frame (async, no clk edge) -> all outputs 0
//    immediately, locked=0, next frame requires new sync.
//  6 MSB_FIRST=0, same stream as 2 -> out0=4'h5, out1=4'hA.

Source files
------------

// File: rtl/tdm_demux_1to2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_1to2_pkg
// Description : Shared definitions for the 2:1 TDM link (states, channel ids).
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_demux_1to2_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_RUN  = 1'b1
    } tdm_state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    localparam int TDM_WORD_W_DEF = 8;

endpackage : tdm_demux_1to2_pkg
`default_nettype wire

// File: rtl/tdm_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_shift_reg
// Description : Per-channel deserialiser; q is the look-ahead word (after any
//               clear/shift applied this cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_shift_reg
    import tdm_demux_1to2_pkg::*;
#(
    parameter int WORD_W    = TDM_WORD_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              d,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] sh_q;
    logic [WORD_W-1:0] sh_d;
    logic [WORD_W-1:0] base;
    logic [WORD_W-1:0] shifted;

    // clr together with en restarts the word with d as its first bit
    assign base = clr ? '0 : sh_q;

    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {base[WORD_W-2:0], d};
        end else begin : g_lsb
            assign shifted = {d, base[WORD_W-1:1]};
        end
    endgenerate

    always_comb begin
        sh_d = base;
        if (en) begin
            sh_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q = sh_d;

endmodule : tdm_shift_reg
`default_nettype wire

// File: rtl/tdm_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_1to2
// Description : 1:2 TDM receiver - frame-sync hunt, bit steering, per-channel
//               deserialisation and per-frame parallel word output.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_1to2
    import tdm_demux_1to2_pkg::*;
#(
    parameter int WORD_W    = TDM_WORD_W_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              sync,
    output logic              sel,
    output logic [WORD_W-1:0] out0,
    output logic [WORD_W-1:0] out1,
    output logic              frame_valid,
    output logic              locked,
    output logic              sync_err
);

    localparam int              CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    tdm_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] out0_q, out0_d;
    logic [WORD_W-1:0] out1_q, out1_d;
    logic              fv_q, fv_d;
    logic              serr_q, serr_d;

    logic              sh_clr;
    logic              sh_en0;
    logic              sh_en1;
    logic [WORD_W-1:0] word0;
    logic [WORD_W-1:0] word1;
    logic              frm_start;
    logic              last_bit;

    tdm_shift_reg #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sh_ch0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sh_clr),
        .en    (sh_en0),
        .d     (din),
        .q     (word0)
    );

    tdm_shift_reg #(
        .WORD_W    (WORD_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sh_ch1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sh_clr),
        .en    (sh_en1),
        .d     (din),
        .q     (word1)
    );

    assign frm_start = (sel_q == CH0) && (cnt_q == '0);
    assign last_bit  = (sel_q == CH1) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        fv_d    = 1'b0;
        serr_d  = 1'b0;
        sh_clr  = 1'b0;
        sh_en0  = 1'b0;
        sh_en1  = 1'b0;

        if (din_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (sync) begin
                        state_d = ST_RUN;
                        sh_clr  = 1'b1;
                        sh_en0  = 1'b1;
                        sel_d   = CH1;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (sync && !frm_start && !last_bit) begin
                        // Misplaced sync: drop the partial frame, restart on this bit
                        serr_d = 1'b1;
                        sh_clr = 1'b1;
                        sh_en0 = 1'b1;
                        sel_d  = CH1;
                        cnt_d  = '0;
                    end else begin
                        serr_d = sync && last_bit;
                        if (sel_q == CH0) begin
                            sh_en0 = 1'b1;
                            sel_d  = CH1;
                        end else begin
                            sh_en1 = 1'b1;
                            sel_d  = CH0;
                            if (last_bit) begin
                                cnt_d  = '0;
                                out0_d = word0;
                                out1_d = word1;
                                fv_d   = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            sel_q   <= CH0;
            cnt_q   <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            fv_q    <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            fv_q    <= fv_d;
            serr_q  <= serr_d;
        end
    end

    assign sel         = sel_q;
    assign out0        = out0_q;
    assign out1        = out1_q;
    assign frame_valid = fv_q;
    assign sync_err    = serr_q;
    assign locked      = (state_q == ST_RUN);

endmodule : tdm_demux_1to2
`default_nettype wire

// File: tb/tb_tdm_demux_1to2.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_tdm_demux_1to2
// Description : Scoreboard bench for tdm_demux_1to2, MSB- and LSB-first copies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1to2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       din       = 1'b0;
    logic       din_valid = 1'b0;
    logic       sync      = 1'b0;

    logic       sel_m, fv_m, lk_m, se_m;
    logic [3:0] out0_m, out1_m;
    logic       sel_l, fv_l, lk_l, se_l;
    logic [3:0] out0_l, out1_l;

    int n_checks = 0;
    int n_fail   = 0;
    int serr_m_seen = 0;
    int serr_l_seen = 0;
    int serr_exp    = 0;

    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    tdm_demux_1to2 #(.WORD_W(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .sel(sel_m), .out0(out0_m), .out1(out1_m), .frame_valid(fv_m),
        .locked(lk_m), .sync_err(se_m)
    );

    tdm_demux_1to2 #(.WORD_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sync(sync),
        .sel(sel_l), .out0(out0_l), .out1(out1_l), .frame_valid(fv_l),
        .locked(lk_l), .sync_err(se_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected words whenever a frame is presented
    always @(negedge clk) begin
        if (fv_m) begin
            if (q_m.size() == 0) check("frame_msb_unexpected", {out0_m, out1_m}, 32'hFFFF_FFFF);
            else                 check("frame_msb", {out0_m, out1_m}, q_m.pop_front());
        end
        if (fv_l) begin
            if (q_l.size() == 0) check("frame_lsb_unexpected", {out0_l, out1_l}, 32'hFFFF_FFFF);
            else                 check("frame_lsb", {out0_l, out1_l}, q_l.pop_front());
        end
        if (se_m) serr_m_seen++;
        if (se_l) serr_l_seen++;
    end

    task automatic drive(input logic v, input logic d, input logic s);
        @(negedge clk);
        din_valid = v;
        din       = d;
        sync      = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    // bits[0] is sent first; a two-cycle invalid gap (with sync high) precedes bit gap_at
    task automatic send(input logic [15:0] bits, input logic [15:0] syncs,
                        input int n, input int gap_at);
        logic s0, s1;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                drive(1'b0, 1'b1, 1'b1);
                s0 = sel_m;
                s1 = sel_l;
                drive(1'b0, 1'b0, 1'b1);
                check("gap_sel_msb", {31'd0, sel_m}, {31'd0, s0});
                check("gap_sel_lsb", {31'd0, sel_l}, {31'd0, s1});
            end
            drive(1'b1, bits[i], syncs[i]);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] m, input logic [7:0] l);
        check({name, "_msb"}, {out0_m, out1_m}, m);
        check({name, "_lsb"}, {out0_l, out1_l}, l);
    endtask

    initial begin
        // Test 1: reset state, then ones without sync
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("reset_outs", 8'h00, 8'h00);
        check("reset_lock", {lk_m, lk_l, sel_m, sel_l, fv_m, fv_l, se_m, se_l}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
        idle(2);
        check("hunt_lock", {lk_m, lk_l}, 2'b00);
        check_outs("hunt_outs", 8'h00, 8'h00);

        // Test 2: single frame A/5
        q_m.push_back(8'hA5); q_l.push_back(8'h5A);
        send(16'h0099, 16'h0001, 8, -1);
        idle(2);
        check("frame1_sel", {sel_m, sel_l}, 2'b00);
        check("frame1_lock", {lk_m, lk_l}, 2'b11);
        check_outs("frame1_outs", 8'hA5, 8'h5A);

        // Test 3: back-to-back A/5 then 3/C with mid-frame gaps
        q_m.push_back(8'hA5); q_l.push_back(8'h5A);
        q_m.push_back(8'h3C); q_l.push_back(8'hC3);
        send(16'h0099, 16'h0001, 8, 3);
        send(16'h005A, 16'h0001, 8, 5);
        idle(2);
        check_outs("b2b_outs", 8'h3C, 8'hC3);
        check("b2b_serr", serr_m_seen + serr_l_seen, 0);

        // Test 4: sync after 3 bits -> error, outputs held, then C/2 frame
        send(16'h0007, 16'h0000, 3, -1);
        serr_exp++;
        q_m.push_back(8'hC2); q_l.push_back(8'h34);
        send(16'h0001, 16'h0001, 1, -1);
        idle(2);
        check("resync_serr_msb", serr_m_seen, serr_exp);
        check("resync_serr_lsb", serr_l_seen, serr_exp);
        check_outs("resync_held", 8'h3C, 8'hC3);
        send(16'h0012, 16'h0000, 7, -1);
        idle(2);
        check_outs("resync_outs", 8'hC2, 8'h34);

        // Sync on the completing ch1 bit: frame completes and error pulses
        serr_exp++;
        q_m.push_back(8'h1E); q_l.push_back(8'h87);
        q_m.push_back(8'hA5); q_l.push_back(8'h5A);
        send(16'h006A, 16'h0081, 8, -1);
        send(16'h0099, 16'h0000, 8, -1);
        idle(2);
        check("last_serr_msb", serr_m_seen, serr_exp);
        check("last_serr_lsb", serr_l_seen, serr_exp);
        check_outs("after_last", 8'hA5, 8'h5A);

        // Test 5: asynchronous reset mid-frame
        send(16'h0007, 16'h0001, 3, -1);
        @(posedge clk);
        #2;
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #0.5;
        check_outs("async_rst_outs", 8'h00, 8'h00);
        check("async_rst_ctl", {lk_m, lk_l, sel_m, sel_l, fv_m, fv_l, se_m, se_l}, 8'h00);
        #0.5;
        rst_n = 1'b1;
        send(16'h0099, 16'h0000, 8, -1);
        idle(2);
        check("post_rst_lock", {lk_m, lk_l}, 2'b00);
        check_outs("post_rst_outs", 8'h00, 8'h00);
        q_m.push_back(8'h3C); q_l.push_back(8'hC3);
        send(16'h005A, 16'h0001, 8, -1);
        idle(3);
        check("relock", {lk_m, lk_l}, 2'b11);
        check_outs("relock_outs", 8'h3C, 8'hC3);

        check("pending_msb", q_m.size(), 0);
        check("pending_lsb", q_l.size(), 0);
        check("final_serr_msb", serr_m_seen, serr_exp);
        check("final_serr_lsb", serr_l_seen, serr_exp);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tdm_demux_1to2
`default_nettype wire
